// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the fp_* blocks (int_to_fp, fp_add_seq, fp_to_int).
package fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned WORD_W  = 1 + EXP_W + FRAC_W;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  // Field offsets inside a packed binary32 word
  localparam int unsigned SIGN_BIT = WORD_W - 1;
  localparam int unsigned EXP_LSB  = FRAC_W;

  // Datapath widths: significand with hidden bit, aligned field with guard/round/sticky,
  // sum with carry-out, and leading-zero count of the sum.
  localparam int unsigned SIG_W       = FRAC_W + 1;
  localparam int unsigned ALN_W       = SIG_W + 3;
  localparam int unsigned SUM_W       = ALN_W + 1;
  localparam int unsigned LZC_W       = 5;
  localparam int unsigned NEXP_W      = EXP_W + 2;
  localparam int unsigned ALIGN_LIMIT = ALN_W - 1;
  localparam int unsigned SHX_W       = ALN_W + ALIGN_LIMIT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4
  } fp_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [SIG_W-1:0]  sig;
  } fp_unpacked_t;

  // Split a word into sign/exponent/significand; denormals flush to signed zero
  function automatic fp_unpacked_t fp_unpack(input logic [WORD_W-1:0] w, input logic flip);
    fp_unpacked_t u;
    u.sign = w[SIGN_BIT] ^ flip;
    u.exp  = w[EXP_LSB +: EXP_W];
    if (u.exp == '0) begin
      u.sig = '0;
    end else begin
      u.sig = {1'b1, w[FRAC_W-1:0]};
    end
    return u;
  endfunction

  function automatic logic fp_is_nan(input logic [WORD_W-1:0] w);
    return (&w[EXP_LSB +: EXP_W]) & (|w[FRAC_W-1:0]);
  endfunction

  function automatic logic fp_is_inf(input logic [WORD_W-1:0] w);
    return (&w[EXP_LSB +: EXP_W]) & ~(|w[FRAC_W-1:0]);
  endfunction

endpackage

// File: rtl/fp_add_seq_lzc.sv
// Combinational leading-zero counter over the 28-bit adder output.
module fp_add_seq_lzc
  import fp_pkg::*;
(
  input  logic [SUM_W-1:0] value,
  output logic [LZC_W-1:0] lz_c
);

  // Highest set bit wins; all-zero input reports SUM_W
  always_comb begin
    lz_c = LZC_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (value[i]) begin
        lz_c = LZC_W'(SUM_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle binary32 adder/subtractor: unpack, align, add, normalise, round.
module fp_add_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        flag_invalid,
  output logic        flag_overflow,
  output logic        flag_inexact
);

  fp_state_t           state;

  fp_unpacked_t        ua, ub;
  logic                spec_en;
  logic [WORD_W-1:0]   spec_res;
  logic                spec_inv;

  logic                sx, sy;
  logic [EXP_W-1:0]    xexp;
  logic [ALN_W-1:0]    mx, my;

  logic [SUM_W-1:0]    sum_r;
  logic                sum_sign;
  logic [EXP_W-1:0]    sum_exp;

  logic [ALN_W-1:0]    nsig_r;
  logic [NEXP_W-1:0]   nexp_r;
  logic                nsign_r;
  logic                nzero_r;
  logic                nzero_sign_r;
  logic                nuf_r;

  fp_unpacked_t        ua_c, ub_c;
  logic                nan_a_c, nan_b_c, inf_a_c, inf_b_c;
  logic                spec_c, spec_inv_c;
  logic [WORD_W-1:0]   spec_res_c;

  // Unpack the live inputs; only captured when a start is accepted
  always_comb begin
    ua_c    = fp_unpack(a, 1'b0);
    ub_c    = fp_unpack(b, sub);
    nan_a_c = fp_is_nan(a);
    nan_b_c = fp_is_nan(b);
    inf_a_c = fp_is_inf(a);
    inf_b_c = fp_is_inf(b);
  end

  // Resolve NaN/inf/zero operands up front; the result rides along to ROUND
  always_comb begin
    spec_c     = 1'b1;
    spec_res_c = '0;
    spec_inv_c = 1'b0;
    if (nan_a_c || nan_b_c || (inf_a_c && inf_b_c && (ua_c.sign != ub_c.sign))) begin
      spec_res_c = QNAN;
      spec_inv_c = 1'b1;
    end else if (inf_a_c) begin
      spec_res_c = {ua_c.sign, ua_c.exp, ua_c.sig[FRAC_W-1:0]};
    end else if (inf_b_c) begin
      spec_res_c = {ub_c.sign, ub_c.exp, ub_c.sig[FRAC_W-1:0]};
    end else if ((ua_c.exp == '0) && (ub_c.exp == '0)) begin
      spec_res_c = {ua_c.sign & ub_c.sign, (WORD_W-1)'(0)};
    end else if (ub_c.exp == '0) begin
      spec_res_c = {ua_c.sign, ua_c.exp, ua_c.sig[FRAC_W-1:0]};
    end else if (ua_c.exp == '0) begin
      spec_res_c = {ub_c.sign, ub_c.exp, ub_c.sig[FRAC_W-1:0]};
    end else begin
      spec_c = 1'b0;
    end
  end

  fp_unpacked_t        xo_c, yo_c;
  logic                x_is_a_c;
  logic [EXP_W-1:0]    dshift_c;
  logic [SHX_W-1:0]    ext_c;
  logic [ALN_W-1:0]    mx_c, my_c;

  // ALIGN: order by magnitude, shift the smaller significand right with sticky
  always_comb begin
    x_is_a_c = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
    xo_c     = x_is_a_c ? ua : ub;
    yo_c     = x_is_a_c ? ub : ua;
    dshift_c = xo_c.exp - yo_c.exp;
    ext_c    = {yo_c.sig, (SHX_W-SIG_W)'(0)} >> dshift_c;
    mx_c     = {xo_c.sig, 3'b000};
    if (dshift_c >= EXP_W'(ALIGN_LIMIT)) begin
      my_c = ALN_W'(|yo_c.sig);
    end else begin
      my_c = {ext_c[SHX_W-1 -: ALN_W-1],
              ext_c[SHX_W-ALN_W] | (|ext_c[SHX_W-ALN_W-1:0])};
    end
  end

  logic [SUM_W-1:0]    sum_c;

  // ADD: magnitude add or subtract; X >= Y keeps the difference non-negative
  always_comb begin
    if (sx == sy) begin
      sum_c = {1'b0, mx} + {1'b0, my};
    end else begin
      sum_c = {1'b0, mx} - {1'b0, my};
    end
  end

  logic [LZC_W-1:0]    lz_c;
  logic [LZC_W-1:0]    lsh_c;
  logic [ALN_W-1:0]    nsig_c;
  logic [NEXP_W-1:0]   nexp_c;
  logic                nzero_c, nzero_sign_c, nuf_c;

  fp_add_seq_lzc u_lzc (
    .value (sum_r),
    .lz_c  (lz_c)
  );

  // NORM: bring the leading one to the hidden-bit position, flush underflow
  always_comb begin
    lsh_c        = lz_c - LZC_W'(1);
    nsig_c       = '0;
    nexp_c       = '0;
    nzero_c      = 1'b0;
    nzero_sign_c = 1'b0;
    nuf_c        = 1'b0;
    if (sum_r == '0) begin
      nzero_c = 1'b1;
    end else if (sum_r[SUM_W-1]) begin
      nsig_c = {sum_r[SUM_W-1:2], sum_r[1] | sum_r[0]};
      nexp_c = NEXP_W'(sum_exp) + NEXP_W'(1);
    end else if (NEXP_W'(sum_exp) <= NEXP_W'(lsh_c)) begin
      nzero_c      = 1'b1;
      nzero_sign_c = sum_sign;
      nuf_c        = 1'b1;
    end else begin
      nsig_c = ALN_W'(sum_r << lsh_c);
      nexp_c = NEXP_W'(sum_exp) - NEXP_W'(lsh_c);
    end
  end

  logic                rup_c;
  logic [SIG_W:0]      mant_c;
  logic [NEXP_W-1:0]   rexp_c;
  logic [FRAC_W-1:0]   rfrac_c;
  logic [WORD_W-1:0]   res_c;
  logic                inv_c, ovf_c, inx_c;

  // ROUND: nearest-even on guard/round/sticky, then pick special/zero/rounded result
  always_comb begin
    rup_c   = nsig_r[2] & (nsig_r[1] | nsig_r[0] | nsig_r[3]);
    mant_c  = {1'b0, nsig_r[ALN_W-1:3]} + (SIG_W+1)'(rup_c);
    rexp_c  = nexp_r + NEXP_W'(mant_c[SIG_W]);
    rfrac_c = mant_c[SIG_W] ? mant_c[SIG_W-1:1] : mant_c[FRAC_W-1:0];
    res_c   = '0;
    inv_c   = 1'b0;
    ovf_c   = 1'b0;
    inx_c   = 1'b0;
    if (spec_en) begin
      res_c = spec_res;
      inv_c = spec_inv;
    end else if (nzero_r) begin
      res_c = {nzero_sign_r, (WORD_W-1)'(0)};
      inx_c = nuf_r;
    end else if (rexp_c >= NEXP_W'(EXP_MAX)) begin
      res_c = POS_INF | {nsign_r, (WORD_W-1)'(0)};
      ovf_c = 1'b1;
      inx_c = 1'b1;
    end else begin
      res_c = {nsign_r, rexp_c[EXP_W-1:0], rfrac_c};
      inx_c = |nsig_r[2:0];
    end
  end

  // Sequencer and all pipeline/output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact  <= 1'b0;
      ua            <= '0;
      ub            <= '0;
      spec_en       <= 1'b0;
      spec_res      <= '0;
      spec_inv      <= 1'b0;
      sx            <= 1'b0;
      sy            <= 1'b0;
      xexp          <= '0;
      mx            <= '0;
      my            <= '0;
      sum_r         <= '0;
      sum_sign      <= 1'b0;
      sum_exp       <= '0;
      nsig_r        <= '0;
      nexp_r        <= '0;
      nsign_r       <= 1'b0;
      nzero_r       <= 1'b0;
      nzero_sign_r  <= 1'b0;
      nuf_r         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ua            <= ua_c;
            ub            <= ub_c;
            spec_en       <= spec_c;
            spec_res      <= spec_res_c;
            spec_inv      <= spec_inv_c;
            flag_invalid  <= 1'b0;
            flag_overflow <= 1'b0;
            flag_inexact  <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          sx    <= xo_c.sign;
          sy    <= yo_c.sign;
          xexp  <= xo_c.exp;
          mx    <= mx_c;
          my    <= my_c;
          state <= ST_ADD;
        end
        ST_ADD: begin
          sum_r    <= sum_c;
          sum_sign <= sx;
          sum_exp  <= xexp;
          state    <= ST_NORM;
        end
        ST_NORM: begin
          nsig_r       <= nsig_c;
          nexp_r       <= nexp_c;
          nsign_r      <= sum_sign;
          nzero_r      <= nzero_c;
          nzero_sign_r <= nzero_sign_c;
          nuf_r        <= nuf_c;
          state        <= ST_ROUND;
        end
        ST_ROUND: begin
          result        <= res_c;
          flag_invalid  <= inv_c;
          flag_overflow <= ovf_c;
          flag_inexact  <= inx_c;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed self-checking bench for fp_add_seq.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        flag_invalid;
  logic        flag_overflow;
  logic        flag_inexact;

  int tests = 0;
  int fails = 0;

  fp_add_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .sub           (sub),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .flag_invalid  (flag_invalid),
    .flag_overflow (flag_overflow),
    .flag_inexact  (flag_inexact)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'b0, flag_invalid, flag_overflow, flag_inexact};
  endfunction

  // One full operation: checks busy/done timing, result, flags and the hold after done
  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic op_sub, input logic [31:0] exp_res, input logic [2:0] exp_flg);
    a = op_a; b = op_b; sub = op_sub; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, " busy/done mid"}, {30'b0, busy, done}, 32'h2);
      step();
    end
    check({tag, " busy/done at done"}, {30'b0, busy, done}, 32'h1);
    check({tag, " result"}, result, exp_res);
    check({tag, " flags"}, flags(), {29'b0, exp_flg});
    step();
    check({tag, " done drop"}, {31'b0, done}, 32'h0);
    check({tag, " result hold"}, result, exp_res);
  endtask

  int n;
  int ndone;

  initial begin
    reset = 1'b1; start = 1'b1; sub = 1'b0; a = 32'h3F800000; b = 32'h40000000;
    step();
    step();
    check("reset busy/done", {30'b0, busy, done}, 32'h0);
    check("reset result", result, 32'h0);
    check("reset flags", flags(), 32'h0);
    reset = 1'b0; start = 1'b0;
    step();
    step();
    check("idle after reset", {30'b0, busy, done}, 32'h0);

    run_op("1+2", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
    run_op("cancel", 32'hC4EF8000, 32'h44EF8000, 1'b0, 32'h00000000, 3'b000);
    run_op("neg sub", 32'hC4EF8000, 32'h44EF8000, 1'b1, 32'hC56F8000, 3'b000);
    run_op("3-1", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
    run_op("tie even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
    run_op("tie up", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
    run_op("inf-inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
    run_op("nan", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
    run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
    run_op("-inf+1", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
    run_op("denorm+0", 32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
    run_op("-0+-0", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    run_op("-0-+0", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
    run_op("+0+-0", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
    run_op("x-0", 32'h3F800000, 32'h00000000, 1'b1, 32'h3F800000, 3'b000);
    run_op("underflow", 32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 3'b001);

    // Re-pulsed start during ALIGN and NORM is ignored
    a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b1; a = 32'h40800000;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("repulse done", {31'b0, done}, 32'h1);
    check("repulse result", result, 32'h40400000);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) ndone++;
    end
    check("repulse extra dones", 32'(ndone), 32'h0);
    check("repulse idle", {31'b0, busy}, 32'h0);

    // Start held across done: back-to-back op, next done 5 cycles later
    a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; start = 1'b1;
    step();
    a = 32'h40000000; b = 32'h40000000;
    n = 0;
    while (!done && n < 10) begin
      step();
      n++;
    end
    check("b2b first latency", 32'(n), 32'd4);
    check("b2b first result", result, 32'h40400000);
    n = 0;
    step();
    start = 1'b0;
    n++;
    check("b2b accepted", {30'b0, busy, done}, 32'h2);
    while (!done && n < 10) begin
      step();
      n++;
    end
    check("b2b spacing", 32'(n), 32'd5);
    check("b2b second result", result, 32'h40800000);
    step();

    // Reset in ADD aborts without done
    a = 32'h7F7FFFFF; b = 32'h7F7FFFFF; start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("abort busy/done", {30'b0, busy, done}, 32'h0);
    check("abort result", result, 32'h0);
    check("abort flags", flags(), 32'h0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
